// File: rtl/svi_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter (package arb_pkg).
// The optional grant watchdog is enabled by the ARB_TIMEOUT_EN macro; the
// default constants below are used when the top is instantiated bare.
package arb_pkg;

  // Arbiter FSM: either nobody owns the resource or exactly one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_SIZE_DEF    = 8;
  localparam int ARB_TIMEOUT_DEF = 256;

  // Width of an owner index; a single requester still needs a 1-bit field.
  function automatic int idx_w(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/req_if.sv
// Requester-side handshake bundle shared between one requester and the arbiter.
// Handshake: a requester raises req and holds it for the whole burst; a beat
// moves on every cycle where req and gnt are both high; last marks the final
// beat, and dropping req abandons the burst. gnt is always a registered output.
interface ReqI;
  logic req;
  logic last;
  logic gnt;

  modport Arb (input req, input last, output gnt);
  modport Req (output req, output last, input gnt);
endinterface

// File: rtl/svi_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above i_ptr,
// wrapping past SIZE-1 to 0. Rotate down by i_ptr, find-first, rotate back.
module rr_pick
  import arb_pkg::*;
#(
  parameter int SIZE  = ARB_SIZE_DEF,
  parameter int IDX_W = idx_w(SIZE)
) (
  input  logic [SIZE-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W:0] L_SIZE = (IDX_W+1)'(SIZE);

  logic [SIZE-1:0]  w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Bit 0 of the rotated vector corresponds to requester i_ptr.
  assign w_rot   = SIZE'({i_req, i_req} >> i_ptr);
  assign o_found = |i_req;

  // Lowest set bit of the rotated vector (scan high to low, last hit wins).
  always_comb begin
    w_off = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};

  // Undo the rotation modulo SIZE.
  always_comb begin
    if (w_sum >= L_SIZE) o_idx = IDX_W'(w_sum - L_SIZE);
    else                 o_idx = w_sum[IDX_W-1:0];
  end

endmodule

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter over an array of ReqI requesters with burst ownership.
// Optional feature: define ARB_TIMEOUT_EN to force-release an owner that
// holds the grant for TIMEOUT_CYC cycles (o_timeout pulses on that release).
// o_busy mirrors the FSM state (1 = GRANT) for observation.
module svi_rr_arbiter
  import arb_pkg::*;
#(
  parameter  int SIZE        = ARB_SIZE_DEF,
  parameter  int TIMEOUT_CYC = ARB_TIMEOUT_DEF,
  localparam int IDX_W       = idx_w(SIZE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  ReqI.Arb                 p [SIZE-1:0],
  output logic             o_busy,
  output logic [IDX_W-1:0] o_owner,
  output logic [SIZE-1:0]  o_grant_vec,
  output logic             o_timeout
);

  if (SIZE < 1 || SIZE > 64 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("svi_rr_arbiter: SIZE must be 1..64 and TIMEOUT_CYC at least 1");
  end

  arb_state_e       r_state, w_nxt_state;
  logic [IDX_W-1:0] r_owner, w_nxt_owner;
  logic [IDX_W-1:0] r_ptr, w_nxt_ptr;
  logic [SIZE-1:0]  r_gnt_vec, w_nxt_gnt_vec;

  logic [SIZE-1:0]  w_req_vec;
  logic [SIZE-1:0]  w_last_vec;
  logic             w_own_req;
  logic             w_own_last;
  logic             w_release;
  logic             w_to_hit;
  logic [IDX_W-1:0] w_owner_inc;
  logic [IDX_W-1:0] w_search_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;

  // Flatten the interface array and fan the registered grants back out.
  for (genvar k = 0; k < SIZE; k++) begin : g_map
    assign w_req_vec[k]  = p[k].req;
    assign w_last_vec[k] = p[k].last;
    assign p[k].gnt      = r_gnt_vec[k];
  end

  assign w_own_req   = w_req_vec[r_owner];
  assign w_own_last  = w_last_vec[r_owner];
  assign w_owner_inc = (r_owner == IDX_W'(SIZE - 1)) ? '0 : r_owner + 1'b1;

  // While granted the search starts just past the owner, so the releasing
  // requester ends up with the lowest priority.
  assign w_search_ptr = (r_state == GRANT) ? w_owner_inc : r_ptr;

  rr_pick #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (w_req_vec),
    .i_ptr   (w_search_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_forced;

  // Counter value TIMEOUT_CYC-1 means this is the owner's last allowed cycle.
  assign w_to_hit = (r_state == GRANT) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_forced = w_to_hit && w_own_req && !w_own_last;

  // Cycles held by the current owner; restarts on every new grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_cnt <= '0;
    else if ((r_state == GRANT) && !w_release) r_cnt <= r_cnt + 1'b1;
    else                                       r_cnt <= '0;
  end

  // Register the forced release so the pulse lines up with the gnt fall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_timeout <= 1'b0;
    else          r_timeout <= w_forced;
  end

  assign o_timeout = r_timeout;
`else
  assign w_to_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign w_release = (r_state == GRANT) && (!w_own_req || w_own_last || w_to_hit);

  // Next state, owner, pointer and grant vector.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_owner   = r_owner;
    w_nxt_ptr     = r_ptr;
    w_nxt_gnt_vec = r_gnt_vec;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state   = GRANT;
          w_nxt_owner   = w_pick;
          w_nxt_gnt_vec = SIZE'(1) << w_pick;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_nxt_ptr = w_owner_inc;
          if (w_found) begin
            w_nxt_owner   = w_pick;
            w_nxt_gnt_vec = SIZE'(1) << w_pick;
          end else begin
            w_nxt_state   = IDLE;
            w_nxt_owner   = '0;
            w_nxt_gnt_vec = '0;
          end
        end
      end
      default: begin
        w_nxt_state   = IDLE;
        w_nxt_owner   = '0;
        w_nxt_gnt_vec = '0;
      end
    endcase
  end

  // State, owner, pointer and grant registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_gnt_vec <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_owner   <= w_nxt_owner;
      r_ptr     <= w_nxt_ptr;
      r_gnt_vec <= w_nxt_gnt_vec;
    end
  end

  assign o_busy      = (r_state == GRANT);
  assign o_owner     = r_owner;
  assign o_grant_vec = r_gnt_vec;

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Directed bench for svi_rr_arbiter (SIZE=8, TIMEOUT_CYC=4). Define
// ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog release.
module tb_svi_rr_arbiter;

  localparam int SIZE  = 8;
  localparam int IDX_W = 3;

  logic             i_clk;
  logic             i_rst_n;
  logic [SIZE-1:0]  tb_req;
  logic [SIZE-1:0]  tb_last;
  logic [SIZE-1:0]  w_p_gnt;
  logic             o_busy;
  logic [IDX_W-1:0] o_owner;
  logic [SIZE-1:0]  o_grant_vec;
  logic             o_timeout;

  int n_checks;
  int n_errors;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] cur;

  ReqI u_if [SIZE-1:0] ();

  for (genvar k = 0; k < SIZE; k++) begin : g_if
    assign u_if[k].req  = tb_req[k];
    assign u_if[k].last = tb_last[k];
    assign w_p_gnt[k]   = u_if[k].gnt;
  end

  svi_rr_arbiter #(
    .SIZE        (SIZE),
    .TIMEOUT_CYC (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .p           (u_if),
    .o_busy      (o_busy),
    .o_owner     (o_owner),
    .o_grant_vec (o_grant_vec),
    .o_timeout   (o_timeout)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [IDX_W-1:0] owner,
                              input logic [SIZE-1:0] gnt, input logic busy);
    chk({tag, "_owner"}, 32'(o_owner), 32'(owner));
    chk({tag, "_gvec"},  32'(o_grant_vec), 32'(gnt));
    chk({tag, "_pgnt"},  32'(w_p_gnt), 32'(gnt));
    chk({tag, "_busy"},  32'(o_busy), 32'(busy));
  endtask

  // One burst of 'beats' beats by requester k, last on the final beat; the
  // requester drops req right after its release edge.
  task automatic run_burst(input logic [IDX_W-1:0] k, input int beats);
    logic [SIZE-1:0] one;
    one = 8'h01;
    for (int b = 0; b < beats; b++) begin
      expect_state("t2_burst", k, one << k, 1'b1);
      if (b == beats - 1) tb_last[k] = 1'b1;
      tick();
    end
    tb_req[k]  = 1'b0;
    tb_last[k] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_rst_n  = 1'b0;
    tb_req   = '0;
    tb_last  = '0;
    exp_q    = '{3'd5, 3'd6, 3'd2};

    // Reset values
    repeat (2) @(posedge i_clk);
    #1;
    expect_state("reset", 3'd0, 8'h00, 1'b0);
    chk("reset_timeout", 32'(o_timeout), 32'd0);
    i_rst_n = 1'b1;

    // T1: single request in IDLE, 1-cycle latency; abandon leaves ptr=4
    tb_req = 8'h08;
    tick();
    expect_state("t1_grant3", 3'd3, 8'h08, 1'b1);
    tb_req = 8'h00;
    tick();
    expect_state("t1_idle", 3'd0, 8'h00, 1'b0);

    // T2: req 2,5,6 with ptr=4 -> 5, 6, 2 back to back, 3 beats each
    tb_req = 8'h64;
    tick();
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      run_burst(cur, 3);
    end
    // 2 was still requesting on its release edge and is the only one: re-grant
    expect_state("t2_regrant2", 3'd2, 8'h04, 1'b1);
    tick();
    expect_state("t2_idle", 3'd0, 8'h00, 1'b0);

    // T3: requester 0 back-to-back single-beat bursts keeps the grant
    tb_req  = 8'h01;
    tb_last = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_state("t3_b2b", 3'd0, 8'h01, 1'b1);
    end
    tb_req  = 8'h00;
    tb_last = 8'h00;
    tick();
    expect_state("t3_idle", 3'd0, 8'h00, 1'b0);

    // T4: owner 7 abandons mid-burst, pending 1 takes over
    tb_req = 8'h80;
    tick();
    expect_state("t4_grant7", 3'd7, 8'h80, 1'b1);
    tb_req = 8'h82;
    tick();
    expect_state("t4_hold7", 3'd7, 8'h80, 1'b1);
    tb_req = 8'h02;
    tick();
    expect_state("t4_grant1", 3'd1, 8'h02, 1'b1);

    // T5: asynchronous reset mid-burst, then 6 and 2 race with ptr=0
    #3;
    i_rst_n = 1'b0;
    #1;
    expect_state("t5_async", 3'd0, 8'h00, 1'b0);
    tb_req = 8'h44;
    tick();
    expect_state("t5_held", 3'd0, 8'h00, 1'b0);
    i_rst_n = 1'b1;
    tick();
    expect_state("t5_grant2", 3'd2, 8'h04, 1'b1);

    // T6: owner 1 never sends last (ptr=3 after the abandon below)
    tb_req = 8'h00;
    tick();
    expect_state("t6_idle", 3'd0, 8'h00, 1'b0);
    tb_req = 8'h02;
    tick();
    expect_state("t6_grant1", 3'd1, 8'h02, 1'b1);
    tb_req = 8'h12;
    chk("t6_to_c1", 32'(o_timeout), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      expect_state("t6_hold1", 3'd1, 8'h02, 1'b1);
      chk("t6_to_hold", 32'(o_timeout), 32'd0);
    end
    tick();
`ifdef ARB_TIMEOUT_EN
    expect_state("t6_forced", 3'd4, 8'h10, 1'b1);
    chk("t6_to_pulse", 32'(o_timeout), 32'd1);
    tick();
    expect_state("t6_after", 3'd4, 8'h10, 1'b1);
    chk("t6_to_low", 32'(o_timeout), 32'd0);
`else
    expect_state("t6_unbounded", 3'd1, 8'h02, 1'b1);
    chk("t6_to_tied", 32'(o_timeout), 32'd0);
    tick();
    expect_state("t6_unbounded2", 3'd1, 8'h02, 1'b1);
    chk("t6_to_tied2", 32'(o_timeout), 32'd0);
`endif

    tb_req = 8'h00;
    tick();
    expect_state("final_idle", 3'd0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/svi_rr_arbiter.md
# svi_rr_arbiter

Round-robin arbiter that shares a single downstream resource between an array of `ReqI` interface instances. It connects to the whole array through one modport port and drives exactly one one-hot grant at a time. A granted requester holds ownership across a multi-beat burst that ends on `last`. The arbiter sits between the requester array and the shared resource mux, and exports the owner index for that mux.

## Interface
- `SIZE`, 8: number of requesters, i.e. elements of the interface array; legal range 1..64.
- `TIMEOUT_CYC`, 256: maximum cycles one owner may hold the grant; used only under `ARB_TIMEOUT_EN`.
- `i_clk`  input  1  clock; all state changes on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous and active-low.
- `p`  interface  `ReqI.Arb [SIZE-1:0]`  requester array.
  - Per element: `req` and `last` are inputs to the arbiter; `gnt` is an output from it.
  - `ReqI` also carries modport `Req`, with the same signals in the opposite directions.
- `o_busy`  output  1  a grant is active.
- `o_owner`  output  `IDX_W`  index of the current owner; 0 when not busy.
- `o_grant_vec`  output  `SIZE`  flat copy of all `p[k].gnt`; one-hot or zero.
- `o_timeout`  output  1  one-cycle pulse on forced release; tied 0 without the macro.

## Operation
- States: `IDLE` and `GRANT`, encoded as the enum `arb_state_e`.
- Reset values: state `IDLE`, every `gnt` 0, `o_grant_vec` 0, `o_busy` 0, `o_owner` 0, `o_timeout` 0, round-robin pointer `ptr` 0, timeout counter 0.
- `IDLE`:
  - If any `req` is high, select the first requesting index k, searching from `ptr` upward modulo `SIZE`.
  - Next cycle: state `GRANT`, owner = k, `p[k].gnt` = 1.
- `GRANT`:
  - A beat transfers in each cycle where `req & gnt` is high for the owner.
- Release occurs when either of these holds for the owner:
  - `req & last` is high (normal end of burst);
  - `req` is low (abandon, no `last` needed).
- On release:
  - `ptr` ← owner+1 modulo `SIZE`.
  - If another requester, or the releasing one, is requesting in the release cycle, grant passes to the round-robin pick next cycle (state stays `GRANT`, zero bubble).
  - Otherwise the state goes to `IDLE`.
- Because the search starts at owner+1, the releasing requester has lowest priority. If it is the only requester, it is re-granted.
- `gnt` never depends combinationally on `req`; all grants are registered.
- `IDX_W` = max(1, $clog2(`SIZE`)). With `SIZE`=1, `ptr` is constant 0 and the block degenerates to a registered request/grant.

## Timing
- Latency from `req` rising in `IDLE` to `gnt`: 1 cycle.
- Latency from the release cycle to the new owner's `gnt`: 1 cycle. The old `gnt` falls on the same edge, so grants never overlap.
- `o_owner`, `o_busy` and `o_grant_vec` update on the same edge as `gnt`.
- When `req` and `last` are seen together on the first granted cycle, the burst is a single beat: grant is held for exactly 1 cycle.
- Simultaneous requests in `IDLE`: the lowest index at or above `ptr` wins, wrapping past `SIZE-1` to 0.
- Asserting `i_rst_n` low mid-burst clears every `gnt` and all outputs immediately, without waiting for a clock edge; the first grant after deassertion follows normal `IDLE` rules.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on every new grant and increments each `GRANT` cycle.
  - When it reaches `TIMEOUT_CYC` without a release, the owner is force-released through the normal release path, with `ptr` advancing.
  - `o_timeout` pulses high for 1 cycle, aligned with the `gnt` fall.
- Undefined: no counter is built; `o_timeout` is constant 0 and ownership is unbounded.

## Structure
- Package `arb_pkg` holds:
  - the `arb_state_e` enum;
  - the function `idx_w(int size)`;
  - the default constants `ARB_SIZE_DEF` = 8 and `ARB_TIMEOUT_DEF` = 256.
- Interface `ReqI` lives in its own file.
- One sub-module, `rr_pick`: purely combinational. It takes the request vector and `ptr` and returns `found` and `idx`, using a rotate, then find-first, then un-rotate scheme.
- The top module wraps `rr_pick`, the FSM, the owner/`ptr` registers and a generate loop that maps between the flat vectors and `p[k]`.

## Test plan
- Reset, then `req[3]`=1 in `IDLE` → `p[3].gnt`=1 one cycle later; `o_owner`=3, `o_busy`=1.
- `req[2]`, `req[5]` and `req[6]` all high, with `ptr`=4 → grant order 5, then 6, then 2, each burst 3 beats ending on `last`; no idle cycle between owners and no overlapping grants.
- Single requester 0 issuing back-to-back 1-beat bursts → `gnt[0]` stays high continuously; `o_owner` stays 0.
- Owner 7 drops `req` mid-burst without `last` → `gnt[7]` falls next cycle; `ptr`=0; pending `req[1]` is granted.
- `i_rst_n` pulsed low mid-burst, asynchronously → all grants clear before the next edge; after release, `req[6]` and `req[2]` both high → 2 is granted (because `ptr`=0).
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=4, owner 1 never asserts `last` → `gnt[1]` falls after 4 granted cycles; `o_timeout` pulses for 1 cycle; the next requester is granted.
